// File: rtl/noise_collector.sv
`default_nettype none
// ============================================================================
// Module      : noise_collector
// Description : Folds 4-bit noise samples into DATA_WIDTH-bit random words
//               behind a repetition-count health test with sticky failure.
// Revision    : 1.0 - initial release
// ============================================================================
module noise_collector #(
    parameter int DATA_WIDTH = 32,
    parameter int RCT_CUTOFF = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enb,
    input  logic [3:0]            noise_in,
    input  logic                  noise_vld,
    output logic [DATA_WIDTH-1:0] rnd_data,
    output logic                  rnd_vld,
    input  logic                  rnd_rdy,
    output logic                  rct_fail,
    input  logic                  clr_fail
);

    localparam int                c_cnt_w  = $clog2(DATA_WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DATA_WIDTH - 1);
    localparam logic [3:0]        c_cutoff = 4'(RCT_CUTOFF);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2,
        FAIL    = 2'd3
    } state_t;

    state_t                  state_q,    state_d;
    logic [DATA_WIDTH-1:0]   shift_q,    shift_d;
    logic [c_cnt_w-1:0]      bit_cnt_q,  bit_cnt_d;
    logic [DATA_WIDTH-1:0]   rnd_data_q, rnd_data_d;
    logic                    rnd_vld_q,  rnd_vld_d;
    logic                    rct_fail_q, rct_fail_d;
    logic [3:0]              prev_q,     prev_d;
    logic [3:0]              rep_cnt_q,  rep_cnt_d;
    logic                    rep_have_q, rep_have_d;

    logic                    w_accept;
    logic                    w_bit;
    logic [3:0]              w_rep_next;
    logic                    w_fail_hit;
    logic [DATA_WIDTH-1:0]   w_shift_next;

    assign w_accept     = noise_vld && enb && ((state_q == COLLECT) || (state_q == HOLD));
    assign w_bit        = ^noise_in;
    assign w_shift_next = {shift_q[DATA_WIDTH-2:0], w_bit};

    // Run length saturates so a long stuck source cannot wrap back below the cutoff.
    always_comb begin
        w_rep_next = 4'd1;
        if (rep_have_q && (noise_in == prev_q)) begin
            w_rep_next = (rep_cnt_q == 4'hF) ? 4'hF : rep_cnt_q + 4'd1;
        end
    end

    assign w_fail_hit = w_accept && (w_rep_next == c_cutoff);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        rnd_data_d = rnd_data_q;
        rnd_vld_d  = rnd_vld_q;
        rct_fail_d = rct_fail_q;
        prev_d     = prev_q;
        rep_cnt_d  = rep_cnt_q;
        rep_have_d = rep_have_q;

        if (w_accept) begin
            prev_d     = noise_in;
            rep_cnt_d  = w_rep_next;
            rep_have_d = 1'b1;
            if (w_fail_hit) begin
                rct_fail_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                shift_d    = '0;
                bit_cnt_d  = '0;
                rep_have_d = 1'b0;
                rep_cnt_d  = 4'd0;
                if (enb && !rct_fail_q) begin
                    state_d = COLLECT;
                end
            end

            COLLECT: begin
                if (!enb) begin
                    state_d    = IDLE;
                    shift_d    = '0;
                    bit_cnt_d  = '0;
                    rep_have_d = 1'b0;
                    rep_cnt_d  = 4'd0;
                end else if (w_accept) begin
                    // A failing sample wins over a completing one.
                    if (w_fail_hit) begin
                        state_d   = FAIL;
                        shift_d   = '0;
                        bit_cnt_d = '0;
                    end else if (bit_cnt_q == c_last) begin
                        rnd_data_d = w_shift_next;
                        rnd_vld_d  = 1'b1;
                        shift_d    = '0;
                        bit_cnt_d  = '0;
                        state_d    = HOLD;
                    end else begin
                        shift_d   = w_shift_next;
                        bit_cnt_d = bit_cnt_q + c_cnt_w'(1);
                    end
                end
            end

            HOLD: begin
                // A failure detected on the handshake cycle itself still routes to FAIL.
                if (rnd_rdy && rnd_vld_q) begin
                    rnd_vld_d = 1'b0;
                    if (rct_fail_q || w_fail_hit) begin
                        state_d = FAIL;
                    end else if (enb) begin
                        state_d = COLLECT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            FAIL: begin
                rnd_vld_d = 1'b0;
                if (clr_fail) begin
                    rct_fail_d = 1'b0;
                    rep_have_d = 1'b0;
                    rep_cnt_d  = 4'd0;
                    shift_d    = '0;
                    bit_cnt_d  = '0;
                    state_d    = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            rnd_data_q <= '0;
            rnd_vld_q  <= 1'b0;
            rct_fail_q <= 1'b0;
            prev_q     <= 4'd0;
            rep_cnt_q  <= 4'd0;
            rep_have_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            rnd_data_q <= rnd_data_d;
            rnd_vld_q  <= rnd_vld_d;
            rct_fail_q <= rct_fail_d;
            prev_q     <= prev_d;
            rep_cnt_q  <= rep_cnt_d;
            rep_have_q <= rep_have_d;
        end
    end

    assign rnd_data = rnd_data_q;
    assign rnd_vld  = rnd_vld_q;
    assign rct_fail = rct_fail_q;

endmodule
`default_nettype wire

// File: tb/tb_noise_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_noise_collector
// Description : Directed plus randomized scoreboard bench for noise_collector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noise_collector;

    localparam int W   = 32;
    localparam int CUT = 6;

    localparam int M_IDLE    = 0;
    localparam int M_COLLECT = 1;
    localparam int M_HOLD    = 2;
    localparam int M_FAIL    = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         enb = 1'b0;
    logic [3:0]   noise_in = 4'd0;
    logic         noise_vld = 1'b0;
    logic [W-1:0] rnd_data;
    logic         rnd_vld;
    logic         rnd_rdy = 1'b0;
    logic         rct_fail;
    logic         clr_fail = 1'b0;

    always #5 clk = ~clk;

    noise_collector #(.DATA_WIDTH(W), .RCT_CUTOFF(CUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .enb       (enb),
        .noise_in  (noise_in),
        .noise_vld (noise_vld),
        .rnd_data  (rnd_data),
        .rnd_vld   (rnd_vld),
        .rnd_rdy   (rnd_rdy),
        .rct_fail  (rct_fail),
        .clr_fail  (clr_fail)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: mode, accepted-bit list and current run of equal samples.
    int           m_mode = M_IDLE;
    bit           m_bits[$];
    int           m_run  = 0;
    logic [3:0]   m_prev = 4'd0;
    bit           exp_vld  = 1'b0;
    bit           exp_fail = 1'b0;
    logic [W-1:0] sb_q[$];
    bit           mon_on = 1'b0;
    logic [3:0]   last_s = 4'd0;

    bit           mon_prev_vld = 1'b0;
    logic [W-1:0] mon_cur = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic step(input bit e, input bit v, input logic [3:0] s,
                        input bit r, input bit c, input bit rs);
        bit           acc;
        bit           hit;
        bit           push;
        bit           n_vld;
        bit           n_fail;
        logic [W-1:0] word;
        enb = e; noise_vld = v; noise_in = s; rnd_rdy = r; clr_fail = c; rst = rs;
        if (v) last_s = s;
        hit = 1'b0; push = 1'b0; word = '0;
        n_vld = exp_vld; n_fail = exp_fail;
        acc = v && e && !rs && (m_mode == M_COLLECT || m_mode == M_HOLD);
        if (acc) begin
            if (m_run > 0 && s == m_prev) m_run++;
            else m_run = 1;
            m_prev = s;
            hit = (m_run == CUT);
        end
        if (rs) begin
            m_mode = M_IDLE; m_bits.delete(); m_run = 0; n_vld = 0; n_fail = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    m_bits.delete(); m_run = 0;
                    if (e && !n_fail) m_mode = M_COLLECT;
                end
                M_COLLECT: begin
                    if (!e) begin
                        m_mode = M_IDLE; m_bits.delete(); m_run = 0;
                    end else if (acc) begin
                        if (hit) begin
                            n_fail = 1; m_mode = M_FAIL; m_bits.delete();
                        end else begin
                            m_bits.push_back(^s);
                            if (m_bits.size() == W) begin
                                for (int i = 0; i < W; i++) word[W-1-i] = m_bits[i];
                                push = 1; n_vld = 1; m_mode = M_HOLD; m_bits.delete();
                            end
                        end
                    end
                end
                M_HOLD: begin
                    if (hit) n_fail = 1;
                    if (r) begin
                        n_vld = 0;
                        m_mode = n_fail ? M_FAIL : (e ? M_COLLECT : M_IDLE);
                    end
                end
                default: begin
                    if (c) begin
                        n_fail = 0; m_run = 0; m_mode = M_IDLE;
                    end
                end
            endcase
        end
        @(posedge clk);
        #1;
        exp_vld = n_vld;
        exp_fail = n_fail;
        if (push) sb_q.push_back(word);
    endtask

    function automatic logic [3:0] fresh();
        logic [3:0] s;
        s = 4'($urandom_range(0, 15));
        if (s == last_s) s = s + 4'd1;
        return s;
    endfunction

    task automatic feed(input logic [3:0] s, input bit r);
        step(1, 1, s, r, 0, 0);
    endtask

    // Monitor: per-cycle flag compare, word pop on rnd_vld rise, stability while held.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_on) begin
                chk("rnd_vld", {63'd0, rnd_vld}, {63'd0, exp_vld});
                chk("rct_fail", {63'd0, rct_fail}, {63'd0, exp_fail});
                if (rnd_vld === 1'b1) begin
                    if (!mon_prev_vld) begin
                        checks++;
                        if (sb_q.size() == 0) begin
                            errors++;
                            $display("FAIL word_unexpected actual=%0h required=none t=%0t", rnd_data, $time);
                            mon_cur = rnd_data;
                        end else begin
                            mon_cur = sb_q.pop_front();
                            if (rnd_data !== mon_cur) begin
                                errors++;
                                $display("FAIL word actual=%0h required=%0h t=%0t", rnd_data, mon_cur, $time);
                            end
                        end
                    end else begin
                        chk("word_stable", {32'd0, rnd_data}, {32'd0, mon_cur});
                    end
                end
                mon_prev_vld = (rnd_vld === 1'b1);
            end
        end
    end

    initial begin
        bit e, v, r, c, rs;
        logic [3:0] s;

        // Reset state
        step(0, 0, 0, 0, 0, 1);
        mon_on = 1'b1;
        chk("rst_data", {32'd0, rnd_data}, 64'd0);
        chk("rst_vld", {63'd0, rnd_vld}, 64'd0);
        chk("rst_fail", {63'd0, rct_fail}, 64'd0);

        // Alternating 1/3 with rdy held high
        step(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < W; i++) feed((i % 2 == 0) ? 4'h1 : 4'h3, 1);
        chk("alt13_vld", {63'd0, rnd_vld}, 64'd1);
        chk("alt13_data", {32'd0, rnd_data}, 64'hAAAAAAAA);
        chk("alt13_fail", {63'd0, rct_fail}, 64'd0);
        step(1, 0, 0, 1, 0, 0);

        // Back-pressure: hold word 10 cycles while samples keep arriving
        for (int i = 0; i < W; i++) feed(fresh(), 0);
        for (int i = 0; i < 10; i++) feed(fresh(), 0);
        feed(fresh(), 1);
        chk("hs_vld_clear", {63'd0, rnd_vld}, 64'd0);
        for (int i = 0; i < W; i++) feed(fresh(), 0);
        chk("post_hs_vld", {63'd0, rnd_vld}, 64'd1);
        step(1, 0, 0, 1, 0, 0);

        // Six identical samples trigger the health test
        feed(4'h2, 0);
        for (int i = 0; i < CUT; i++) feed(4'h5, 0);
        chk("rct_set", {63'd0, rct_fail}, 64'd1);
        chk("rct_novld", {63'd0, rnd_vld}, 64'd0);
        for (int i = 0; i < 3; i++) feed(fresh(), 1);
        step(0, 0, 0, 0, 1, 0);
        chk("rct_clr", {63'd0, rct_fail}, 64'd0);

        // Partial word dropped by enb low
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) feed((i % 2 == 0) ? 4'h2 : 4'h4, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < W; i++) feed((i % 2 == 0) ? 4'h7 : 4'h0, 0);
        chk("enb_drop_data", {32'd0, rnd_data}, 64'hAAAAAAAA);
        step(1, 0, 0, 1, 0, 0);

        // Completion and cutoff on the same sample
        for (int i = 0; i < W - CUT; i++) feed((i % 2 == 0) ? 4'h1 : 4'h3, 0);
        for (int i = 0; i < CUT; i++) feed(4'h5, 0);
        chk("tie_fail", {63'd0, rct_fail}, 64'd1);
        chk("tie_vld", {63'd0, rnd_vld}, 64'd0);
        step(0, 0, 0, 0, 1, 0);

        // Reset during HOLD
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < W; i++) feed((i % 2 == 0) ? 4'h1 : 4'h3, 0);
        feed(fresh(), 0);
        step(1, 0, 0, 0, 0, 1);
        chk("hold_rst_vld", {63'd0, rnd_vld}, 64'd0);
        chk("hold_rst_data", {32'd0, rnd_data}, 64'd0);
        chk("hold_rst_fail", {63'd0, rct_fail}, 64'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            e  = ($urandom_range(0, 19) != 0);
            v  = ($urandom_range(0, 9) < 7);
            s  = ($urandom_range(0, 2) == 0) ? last_s : 4'($urandom_range(0, 15));
            r  = ($urandom_range(0, 2) == 0);
            c  = ($urandom_range(0, 7) == 0);
            rs = ($urandom_range(0, 499) == 0);
            step(e, v, s, r, c, rs);
        end

        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/noise_collector.md
NOISE_COLLECTOR -- requirements
Module: noise_collector

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, output word width in bits (range 8..64).
REQ-002 SHALL have parameter RCT_CUTOFF, default 6, count of identical consecutive samples that declares failure (range 2..15).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port enb  input  1  collection enable.
REQ-006 SHALL have port noise_in  input  4  noise sample from the upstream noise generator (value 0..15).
REQ-007 SHALL have port noise_vld  input  1  noise_in carries a new sample this cycle.
REQ-008 SHALL have port rnd_data  output  DATA_WIDTH  collected random word.
REQ-009 SHALL have port rnd_vld  output  1  rnd_data valid.
REQ-010 SHALL have port rnd_rdy  input  1  consumer accepts rnd_data.
REQ-011 SHALL have port rct_fail  output  1  sticky repetition-count health-test failure.
REQ-012 SHALL have port clr_fail  input  1  clears a failure.

Function
REQ-013 SHALL implement states IDLE, COLLECT, HOLD and FAIL.
REQ-014 A sample SHALL be accepted only when noise_vld=1, enb=1 and state is COLLECT or HOLD.
REQ-015 Each accepted sample SHALL yield one bit, the XOR of noise_in[3:0].
REQ-016 Bits SHALL be shifted in from the LSB, so the first bit of a word ends at rnd_data[DATA_WIDTH-1].
REQ-017 A bit counter SHALL count 0..DATA_WIDTH-1 and wrap to 0 when a word completes.
REQ-018 IDLE SHALL go to COLLECT when enb=1 and rct_fail=0.
REQ-019 In COLLECT, the sample completing DATA_WIDTH bits SHALL load rnd_data and set rnd_vld the following cycle (1-cycle latency), and the state SHALL go to HOLD.
REQ-020 In HOLD, rnd_data and rnd_vld SHALL stay stable until rnd_rdy=1.
REQ-021 In HOLD, samples SHALL be health-tested but their bits discarded (no second buffer).
REQ-022 On the HOLD handshake cycle (rnd_rdy=1), rnd_vld SHALL clear next cycle; the next state is FAIL if rct_fail=1, else COLLECT if enb=1, else IDLE.
REQ-023 rnd_rdy SHALL be ignored while rnd_vld=0.
REQ-024 enb=0 in COLLECT SHALL go to IDLE and clear the shift register, bit counter and repetition state; the partial word is discarded.
REQ-025 enb=0 in HOLD SHALL NOT withdraw the held word.
REQ-026 The repetition count test SHALL compare each accepted noise_in against the previous accepted sample.
REQ-027 The first sample after reset, IDLE or FAIL exit SHALL set the repetition count to 1.
REQ-028 An equal sample SHALL increment the repetition count and a different sample SHALL reset it to 1.
REQ-029 When the repetition count reaches RCT_CUTOFF, rct_fail SHALL assert the next cycle and hold.
REQ-030 On failure in COLLECT, the partial word SHALL be discarded and the state SHALL go to FAIL.
REQ-031 On failure in HOLD, the held word SHALL still complete its handshake, then the state SHALL go to FAIL.
REQ-032 If a failure and word completion occur in the same cycle, the failure SHALL win: no rnd_vld, state goes to FAIL.
REQ-033 In FAIL, no samples SHALL be accepted and rnd_vld SHALL be 0.
REQ-034 clr_fail=1 in FAIL SHALL clear rct_fail, the repetition state and the shift register, and go to IDLE.
REQ-035 clr_fail SHALL be ignored in other states.

Reset
REQ-036 rst=1 SHALL force: state IDLE, rnd_data=0, rnd_vld=0, rct_fail=0, shift register, bit counter and repetition state cleared.
REQ-037 rst SHALL take priority over all inputs, including mid-word and mid-HOLD.

Verification
REQ-038 Bench SHALL drive enb=1 with 32 valid samples alternating 4'h1, 4'h3, rnd_rdy=1 -> rnd_vld=1 one cycle after the 32nd sample, rnd_data=32'hAAAAAAAA, rct_fail=0.
REQ-039 Bench SHALL complete a word, hold rnd_rdy=0 for 10 cycles while feeding samples, then pulse rnd_rdy -> rnd_data stable throughout; rnd_vld=0 the cycle after rnd_rdy; next word built only from post-handshake samples.
REQ-040 Bench SHALL feed 6 consecutive 4'h5 samples -> rct_fail=1 the cycle after the 6th; no rnd_vld; further samples ignored; clr_fail=1 -> rct_fail=0, state IDLE.
REQ-041 Bench SHALL drop enb after 16 samples, then re-raise it and feed 32 samples of 4'h7/4'h0 alternating -> rnd_data=32'hAAAAAAAA (partial word discarded).
REQ-042 Bench SHALL make the 32nd sample also the 6th repeat of the same value -> rct_fail=1 and rnd_vld stays 0.
REQ-043 Bench SHALL assert rst for 1 cycle during HOLD -> next cycle rnd_vld=0, rnd_data=0, rct_fail=0, state IDLE.
